// File: rtl/quick_cpu_pkg.sv
// Shared encodings for the quick CPU core: opcodes, microcode steps and ALU ops.
package quick_cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_CLC = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] MC_FETCH_OP  = 2'd0;
  localparam logic [1:0] MC_FETCH_ARG = 2'd1;
  localparam logic [1:0] MC_MEM       = 2'd2;

  typedef enum logic [1:0] {
    AluPassA,
    AluAdd,
    AluSub
  } alu_op_e;

endpackage

// File: rtl/quick_cpu_alu.sv
// Combinational accumulator ALU; carry is carry-out for add and borrow for sub.
module quick_cpu_alu
  import quick_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W:0] ext;

  always_comb begin
    ext = {1'b0, a};
    case (op)
      AluAdd:  ext = {1'b0, a} + {1'b0, b};
      AluSub:  ext = {1'b0, a} - {1'b0, b};
      default: ext = {1'b0, a};
    endcase
  end

  assign result = ext[DATA_W-1:0];
  assign carry  = ext[DATA_W];
  assign zero   = (result == '0);

endmodule

// File: rtl/quick_cpu_core_p.sv
// Multi-cycle accumulator CPU with a req/ack memory port.
// Build option QUICK_CPU_CARRY_EN adds a carry flag plus JC/CLC opcodes.
module quick_cpu_core_p
  import quick_cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        mc
);

`ifdef QUICK_CPU_CARRY_EN
  localparam bit CarryEn = 1'b1;
`else
  localparam bit CarryEn = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] PcReset = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [1:0]        mc_q, mc_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] acc_q, acc_d, out_q, out_d;
  logic              halted_q, halted_d, out_valid_q, out_valid_d, carry_q, carry_d;

  logic              step;
  logic [ADDR_W-1:0] arg_addr;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero, alu_carry;

  quick_cpu_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a     (acc_q),
    .b     (mem_rdata),
    .op    (alu_op),
    .result(alu_result),
    .zero  (alu_zero),
    .carry (alu_carry)
  );

  assign arg_addr = mem_rdata[ADDR_W-1:0];
  assign step     = mem_req & mem_ack & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= PcReset;
      addr_q      <= PcReset;
      mc_q        <= MC_FETCH_OP;
      op_q        <= OP_NOP;
      acc_q       <= '0;
      out_q       <= '0;
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      mc_q        <= mc_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      halted_q    <= halted_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
    end
  end

  always_comb begin
    pc_d        = pc_q;
    addr_d      = addr_q;
    mc_d        = mc_q;
    op_d        = op_q;
    acc_d       = acc_q;
    out_d       = out_q;
    halted_d    = halted_q;
    out_valid_d = 1'b0;  // pulse: clears even while ena is low
    carry_d     = carry_q;
    if (step) begin
      unique case (mc_q)
        MC_FETCH_OP: begin
          pc_d = pc_q + ADDR_W'(1);
          op_d = mem_rdata[3:0];
          case (mem_rdata[3:0])
            OP_LDI, OP_LD, OP_ST, OP_ADD, OP_SUB, OP_JMP, OP_JZ: mc_d = MC_FETCH_ARG;
            OP_JC:  if (CarryEn) mc_d = MC_FETCH_ARG;
            OP_CLC: if (CarryEn) carry_d = 1'b0;
            OP_OUT: begin
              out_d       = acc_q;
              out_valid_d = 1'b1;
            end
            OP_HLT:  halted_d = 1'b1;
            default: ;
          endcase
        end
        MC_FETCH_ARG: begin
          pc_d = pc_q + ADDR_W'(1);
          mc_d = MC_FETCH_OP;
          case (op_q)
            OP_LDI: acc_d = mem_rdata;
            OP_JMP: pc_d = arg_addr;
            OP_JZ:  if (alu_zero) pc_d = arg_addr;
            OP_JC:  if (carry_q) pc_d = arg_addr;
            default: begin
              addr_d = arg_addr;
              mc_d   = MC_MEM;
            end
          endcase
        end
        MC_MEM: begin
          mc_d = MC_FETCH_OP;
          case (op_q)
            OP_LD: acc_d = mem_rdata;
            OP_ADD, OP_SUB: begin
              acc_d = alu_result;
              if (CarryEn) carry_d = alu_carry;
            end
            default: ;
          endcase
        end
        default: mc_d = MC_FETCH_OP;
      endcase
    end
  end

  always_comb begin
    // Gating with rst_n drops the request the instant reset asserts.
    mem_req   = rst_n & ~halted_q;
    mem_we    = (mc_q == MC_MEM) && (op_q == OP_ST);
    mem_addr  = (mc_q == MC_MEM) ? addr_q : pc_q;
    mem_wdata = acc_q;
    alu_op    = AluPassA;
    if (mc_q == MC_MEM && op_q == OP_ADD) alu_op = AluAdd;
    if (mc_q == MC_MEM && op_q == OP_SUB) alu_op = AluSub;
  end

  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign pc        = pc_q;
  assign mc        = mc_q;

endmodule

// File: tb/tb_quick_cpu_core_p.sv
// Directed-vector bench for quick_cpu_core_p with a req/ack memory model of programmable latency.
module tb_quick_cpu_core_p;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       mem_req, mem_we, mem_ack, out_valid, halted;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, out_data, pc;
  logic [1:0] mc;

  logic [7:0] mem [256];
  logic [7:0] prog_q [$];
  int         ack_delay = 0;
  int         wait_cnt = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         n;

  int         edge_cnt, out_cnt, out_edge, wr_cnt, stab_err;
  logic [7:0] out_last, out_pc, wr_addr, wr_data, prev_addr;
  logic       prev_we, prev_wait;

  always #5 clk = ~clk;

  quick_cpu_core_p dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .out_data (out_data),
    .out_valid(out_valid),
    .halted   (halted),
    .pc       (pc),
    .mc       (mc)
  );

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  // Single-entry write buffer lets a later load see the stored value.
  assign mem_rdata = (wr_cnt != 0 && mem_addr == wr_addr) ? wr_data : mem[mem_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      edge_cnt <= 0; out_cnt <= 0; out_edge <= -1; out_last <= '0; out_pc <= '0;
      wr_cnt <= 0; stab_err <= 0; prev_wait <= 1'b0; wait_cnt <= 0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (out_valid) begin
        out_cnt <= out_cnt + 1; out_last <= out_data; out_edge <= edge_cnt; out_pc <= pc;
      end
      if (mem_req && mem_ack && ena && mem_we) begin
        wr_cnt <= wr_cnt + 1; wr_addr <= mem_addr; wr_data <= mem_wdata;
      end
      if (prev_wait && (mem_addr !== prev_addr || mem_we !== prev_we)) stab_err <= stab_err + 1;
      prev_wait <= mem_req && !(mem_ack && ena);
      prev_addr <= mem_addr;
      prev_we   <= mem_we;
      if (!mem_req || (mem_ack && ena)) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic load();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < prog_q.size(); i++) mem[i] = prog_q[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ena = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int max, output int cycles);
    cycles = 0;
    while (!halted && cycles < max) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc got %0h want 0", pc); end
    vectors++; if (mc !== 2'd0) begin miscompares++; $display("FAIL rst_mc got %0d want 0", mc); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got %b want 0", halted); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out got %0h want 0", out_data); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_ovalid got %b want 0", out_valid); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", mem_req); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got %b want 0", mem_we); end
    vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL rst_addr got %0h want 0", mem_addr); end
    vectors++; if (mem_wdata !== 8'h00) begin miscompares++; $display("FAIL rst_wdata got %0h want 0", mem_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rel_req got %b want 1", mem_req); end
  endtask

  task automatic test_basic();
    prog_q = {8'h01, 8'h05, 8'h04, 8'h10, 8'h08, 8'h0F};
    load(); mem[8'h10] = 8'h03; ack_delay = 0;
    do_reset();
    run_to_halt(50, n);
    vectors++; if (n !== 7) begin miscompares++; $display("FAIL basic_cycles got %0d want 7", n); end
    vectors++; if (out_cnt !== 1) begin miscompares++; $display("FAIL basic_npulse got %0d want 1", out_cnt); end
    vectors++; if (out_last !== 8'h08) begin miscompares++; $display("FAIL basic_out got %0h want 8", out_last); end
    vectors++; if (out_edge !== 6) begin miscompares++; $display("FAIL basic_out_time got %0d want 6", out_edge); end
    repeat (4) @(negedge clk);
    vectors++; if (pc !== 8'h06) begin miscompares++; $display("FAIL basic_pc_frozen got %0h want 6", pc); end
    vectors++; if (mc !== 2'd0) begin miscompares++; $display("FAIL basic_mc got %0d want 0", mc); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL basic_req_halt got %b want 0", mem_req); end
  endtask

  task automatic test_wait();
    prog_q = {8'h01, 8'h05, 8'h04, 8'h10, 8'h08, 8'h0F};
    load(); mem[8'h10] = 8'h03; ack_delay = 2;
    do_reset();
    run_to_halt(100, n);
    vectors++; if (n !== 21) begin miscompares++; $display("FAIL wait_cycles got %0d want 21", n); end
    vectors++; if (out_edge !== 18) begin miscompares++; $display("FAIL wait_out_time got %0d want 18", out_edge); end
    vectors++; if (out_last !== 8'h08) begin miscompares++; $display("FAIL wait_out got %0h want 8", out_last); end
    vectors++; if (stab_err !== 0) begin miscompares++; $display("FAIL wait_stable got %0d want 0", stab_err); end
    ack_delay = 0;
  endtask

  task automatic test_jz();
    prog_q = {8'h01, 8'h00, 8'h07, 8'h20, 8'h08, 8'h0F};
    load(); mem[8'h20] = 8'h08; mem[8'h21] = 8'h0F;
    do_reset();
    run_to_halt(50, n);
    vectors++; if (out_pc !== 8'h21) begin miscompares++; $display("FAIL jz_taken_pc got %0h want 21", out_pc); end
    vectors++; if (out_last !== 8'h00) begin miscompares++; $display("FAIL jz_taken_out got %0h want 0", out_last); end
    vectors++; if (n !== 6) begin miscompares++; $display("FAIL jz_taken_cycles got %0d want 6", n); end
    mem[1] = 8'h01;
    do_reset();
    run_to_halt(50, n);
    vectors++; if (out_pc !== 8'h05) begin miscompares++; $display("FAIL jz_fall_pc got %0h want 5", out_pc); end
    vectors++; if (out_last !== 8'h01) begin miscompares++; $display("FAIL jz_fall_out got %0h want 1", out_last); end
    vectors++; if (pc !== 8'h06) begin miscompares++; $display("FAIL jz_fall_end_pc got %0h want 6", pc); end
  endtask

  task automatic test_st_ld();
    prog_q = {8'h01, 8'hAA, 8'h03, 8'h30, 8'h01, 8'h00, 8'h02, 8'h30, 8'h08, 8'h0F};
    load();
    do_reset();
    run_to_halt(50, n);
    vectors++; if (n !== 12) begin miscompares++; $display("FAIL stld_cycles got %0d want 12", n); end
    vectors++; if (wr_cnt !== 1) begin miscompares++; $display("FAIL stld_nwrites got %0d want 1", wr_cnt); end
    vectors++; if (wr_addr !== 8'h30) begin miscompares++; $display("FAIL stld_waddr got %0h want 30", wr_addr); end
    vectors++; if (wr_data !== 8'hAA) begin miscompares++; $display("FAIL stld_wdata got %0h want aa", wr_data); end
    vectors++; if (out_last !== 8'hAA) begin miscompares++; $display("FAIL stld_out got %0h want aa", out_last); end
  endtask

  task automatic test_sub();
    prog_q = {8'h01, 8'h03, 8'h05, 8'h40, 8'h08, 8'h0F};
    load(); mem[8'h40] = 8'h05;
    do_reset();
    run_to_halt(50, n);
    vectors++; if (out_last !== 8'hFE) begin miscompares++; $display("FAIL sub_out got %0h want fe", out_last); end
    vectors++; if (n !== 7) begin miscompares++; $display("FAIL sub_cycles got %0d want 7", n); end
  endtask

  task automatic test_carry();
    prog_q = {8'h01, 8'hFF, 8'h04, 8'h40, 8'h08, 8'h09, 8'h10, 8'h0F};
    load(); mem[8'h40] = 8'h01; mem[8'h10] = 8'h0F;
    do_reset();
    run_to_halt(50, n);
    vectors++; if (out_last !== 8'h00) begin miscompares++; $display("FAIL carry_acc got %0h want 0", out_last); end
    vectors++; if (out_cnt !== 1) begin miscompares++; $display("FAIL carry_npulse got %0d want 1", out_cnt); end
`ifdef QUICK_CPU_CARRY_EN
    vectors++; if (pc !== 8'h11) begin miscompares++; $display("FAIL carry_jc_pc got %0h want 11", pc); end
`else
    vectors++; if (pc !== 8'h08) begin miscompares++; $display("FAIL carry_nop9_pc got %0h want 8", pc); end
`endif
  endtask

  task automatic test_wrap();
    prog_q = {8'h06, 8'hFF};
    load(); mem[8'hFF] = 8'h08;
    do_reset();
    repeat (4) @(negedge clk);
    vectors++; if (out_cnt !== 1) begin miscompares++; $display("FAIL wrap_npulse got %0d want 1", out_cnt); end
    vectors++; if (out_pc !== 8'h00) begin miscompares++; $display("FAIL wrap_pc got %0h want 0", out_pc); end
    vectors++; if (out_edge !== 3) begin miscompares++; $display("FAIL wrap_time got %0d want 3", out_edge); end
  endtask

  task automatic test_ena();
    prog_q = {8'h01, 8'h05, 8'h04, 8'h10, 8'h08, 8'h0F};
    load(); mem[8'h10] = 8'h03;
    do_reset();
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (pc !== 8'h02) begin miscompares++; $display("FAIL ena_pc got %0h want 2", pc); end
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL ena_req got %b want 1", mem_req); end
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (pc !== 8'h03) begin miscompares++; $display("FAIL ena_arg_pc got %0h want 3", pc); end
    vectors++; if (mc !== 2'd1) begin miscompares++; $display("FAIL ena_arg_mc got %0d want 1", mc); end
    ena = 1'b1;
    run_to_halt(50, n);
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL ena_rest_cycles got %0d want 4", n); end
    vectors++; if (out_last !== 8'h08) begin miscompares++; $display("FAIL ena_out got %0h want 8", out_last); end
  endtask

  task automatic test_reset_mid();
    int k;
    prog_q = {8'h01, 8'h05, 8'h04, 8'h10, 8'h08, 8'h0F};
    load(); mem[8'h10] = 8'h03; ack_delay = 5;
    do_reset();
    k = 0;
    while (mc !== 2'd2 && k < 100) begin @(negedge clk); k++; end
    vectors++; if (mc !== 2'd2) begin miscompares++; $display("FAIL mid_reach_mem got %0d want 2", mc); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_req got %b want 0", mem_req); end
    vectors++; if (pc !== 8'h00) begin miscompares++; $display("FAIL mid_pc got %0h want 0", pc); end
    vectors++; if (mc !== 2'd0) begin miscompares++; $display("FAIL mid_mc got %0d want 0", mc); end
    ack_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_to_halt(50, n);
    vectors++; if (n !== 7) begin miscompares++; $display("FAIL mid_restart_cycles got %0d want 7", n); end
    vectors++; if (out_last !== 8'h08) begin miscompares++; $display("FAIL mid_restart_out got %0h want 8", out_last); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_jz();
    test_st_ld();
    test_sub();
    test_carry();
    test_wrap();
    test_ena();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
